aes_enc_sequencer: RTL and testbench

//  Host-facing controller for the iterative AES-128 encryption core.
//  - Accepts a key write and plaintexts over valid/ready handshakes.
//  - Drives the core's Krdy/Drdy/EN strobes, waits for Dvld, then buffers the ciphertext.
//  - Enforces key-before-data ordering and a watchdog timeout.
//  - Sits between the SAKURA-G host register file and the AES core.

---
 rtl/aes_seq_pkg.sv | 18 +
 rtl/aes_seq_watchdog.sv | 43 ++++
 rtl/aes_enc_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_aes_enc_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-128 encryption sequencer.
package aes_seq_pkg;

    localparam int unsigned AES_BLK_W   = 128;
    localparam int unsigned NOMINAL_LAT = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_KWAIT,
        ST_LOAD,
        ST_RUN,
        ST_ERROR
    } seq_state_e;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_seq_watchdog.sv
// Loadable down-counter watchdog: start reloads TIMEOUT_CYC, stop disarms,
// expired holds while armed at zero.
module aes_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = CW'(TIMEOUT_CYC);
            run_d = 1'b1;
        end else if (stop) begin
            run_d = 1'b0;
        end else if (run_q && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expired = run_q && (cnt_q == '0);

endmodule

// File: rtl/aes_enc_sequencer.sv
// Host-side sequencer for the iterative AES-128 core: key load, plaintext issue,
// ciphertext buffering, watchdog. Define AES_SEQ_TRIG_EN to build the scope trigger.
module aes_enc_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             key_wr,
    input  logic [127:0]     key_in,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [127:0]     pt_in,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [127:0]     ct_out,
    output logic             err,
    output logic [CNT_W-1:0] op_cnt,
    output logic             trig,
    output logic             aes_en,
    output logic             aes_krdy,
    output logic             aes_drdy,
    output logic [127:0]     aes_kin,
    output logic [127:0]     aes_din,
    input  logic             aes_kvld,
    input  logic             aes_dvld,
    input  logic             aes_bsy,
    input  logic [127:0]     aes_dout
);

    seq_state_e state_q, state_d;

    aes_blk_t         key_q, key_d, pt_q, pt_d, ct_q, ct_d, kin_q, kin_d, din_q, din_d;
    logic             key_pend_q, key_pend_d, key_ok_q, key_ok_d, err_q, err_d;
    logic             ct_valid_q, ct_valid_d, krdy_q, krdy_d, drdy_q, drdy_d, en_q, en_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic             wd_start, wd_stop, wd_expired, pt_fire;

    aes_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk     (CLK),
        .rst_n   (RSTn),
        .start   (wd_start),
        .stop    (wd_stop),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (key_wr || key_pend_q) state_d = ST_KEY;
                      else if (pt_fire)         state_d = ST_LOAD;
            ST_KEY:   state_d = ST_KWAIT;
            ST_KWAIT: if (aes_kvld) state_d = ST_IDLE;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN:   if (aes_dvld)        state_d = ST_IDLE;
                      else if (wd_expired) state_d = ST_ERROR;
            ST_ERROR: if (key_wr) state_d = ST_KEY;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pt_ready = (state_q == ST_IDLE) && key_ok_q && !ct_valid_q && !key_pend_q;
        pt_fire  = pt_valid && pt_ready;
        wd_start = (state_q == ST_LOAD);
        wd_stop  = (state_q == ST_RUN) && (aes_dvld || wd_expired);
    end

    // Core strobes and buses are registered, so they lag the KEY/LOAD state by one cycle.
    always_comb begin
        key_d      = key_wr ? key_in : key_q;
        pt_d       = pt_fire ? pt_in : pt_q;
        krdy_d     = (state_q == ST_KEY);
        kin_d      = (state_q == ST_KEY) ? key_q : kin_q;
        drdy_d     = (state_q == ST_LOAD);
        din_d      = (state_q == ST_LOAD) ? pt_q : din_q;
        en_d       = (state_d != ST_ERROR);
        key_pend_d = key_pend_q;
        key_ok_d   = key_ok_q;
        err_d      = err_q;
        ct_d       = ct_q;
        ct_valid_d = ct_valid_q;
        op_cnt_d   = op_cnt_q;

        if (key_wr && (state_q inside {ST_KEY, ST_KWAIT, ST_LOAD, ST_RUN}))
            key_pend_d = 1'b1;
        else if (state_q == ST_IDLE && state_d == ST_KEY)
            key_pend_d = 1'b0;

        if (state_q == ST_KWAIT && aes_kvld) begin
            key_ok_d = 1'b1;
            err_d    = 1'b0;
        end
        if (state_q == ST_RUN && state_d == ST_ERROR) begin
            key_ok_d = 1'b0;
            err_d    = 1'b1;
        end
        if (key_wr) err_d = 1'b0;

        if (state_q == ST_RUN && aes_dvld) begin
            ct_d       = aes_dout;
            ct_valid_d = 1'b1;
            op_cnt_d   = op_cnt_q + 1'b1;
        end else if (ct_valid_q && ct_ready) begin
            ct_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_q      <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            kin_q      <= '0;
            din_q      <= '0;
            key_pend_q <= 1'b0;
            key_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            ct_valid_q <= 1'b0;
            krdy_q     <= 1'b0;
            drdy_q     <= 1'b0;
            en_q       <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            key_q      <= key_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
            kin_q      <= kin_d;
            din_q      <= din_d;
            key_pend_q <= key_pend_d;
            key_ok_q   <= key_ok_d;
            err_q      <= err_d;
            ct_valid_q <= ct_valid_d;
            krdy_q     <= krdy_d;
            drdy_q     <= drdy_d;
            en_q       <= en_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

`ifdef AES_SEQ_TRIG_EN
    logic trig_q, trig_d;

    always_comb begin
        trig_d = trig_q;
        if (drdy_q)
            trig_d = 1'b1;
        else if (state_q == ST_RUN && (aes_dvld || wd_expired))
            trig_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) trig_q <= 1'b0;
        else       trig_q <= trig_d;
    end

    assign trig = trig_q;
`else
    assign trig = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RSTn && state_q == ST_IDLE) assert (!aes_bsy);
    end

    assign ct_valid = ct_valid_q;
    assign ct_out   = ct_q;
    assign err      = err_q;
    assign op_cnt   = op_cnt_q;
    assign aes_en   = en_q;
    assign aes_krdy = krdy_q;
    assign aes_drdy = drdy_q;
    assign aes_kin  = kin_q;
    assign aes_din  = din_q;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Directed bench for aes_enc_sequencer with a behavioural AES core stand-in
// (FIPS-197 vector for the reference key/pt, a simple mix function otherwise).
module tb_aes_enc_sequencer;

    localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C0 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KX = 128'hdeadbeef_00000000_cafef00d_11111111;

    logic         CLK = 1'b0, RSTn = 1'b0;
    logic         key_wr = 1'b0, pt_valid = 1'b0, ct_ready = 1'b0;
    logic [127:0] key_in = '0, pt_in = '0;
    logic         pt_ready, ct_valid, err, trig, aes_en, aes_krdy, aes_drdy;
    logic [127:0] ct_out, aes_kin, aes_din;
    logic [2:0]   op_cnt;
    logic         aes_kvld, aes_dvld, aes_bsy;
    logic [127:0] aes_dout;

    int  n_checks = 0, n_errors = 0;
    logic hang = 1'b0, saw_krdy, trig_mid;
    logic [127:0] kin_seen;

    always #5 CLK = ~CLK;

    aes_enc_sequencer #(.TIMEOUT_CYC(32), .CNT_W(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .key_wr(key_wr), .key_in(key_in),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_in(pt_in),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_out(ct_out),
        .err(err), .op_cnt(op_cnt), .trig(trig),
        .aes_en(aes_en), .aes_krdy(aes_krdy), .aes_drdy(aes_drdy),
        .aes_kin(aes_kin), .aes_din(aes_din),
        .aes_kvld(aes_kvld), .aes_dvld(aes_dvld), .aes_bsy(aes_bsy), .aes_dout(aes_dout)
    );

    function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_0f0f0f0f_a5a5a5a5_f0f0f0f0;
    endfunction

    // Core model: kvld one cycle after krdy; dvld 11 cycles after drdy is sampled.
    logic [127:0] m_key, m_din;
    logic [3:0]   m_cnt;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_key <= '0; m_din <= '0; m_cnt <= '0;
            aes_kvld <= 1'b0; aes_dvld <= 1'b0; aes_dout <= '0;
        end else begin
            aes_kvld <= aes_krdy;
            if (aes_krdy) m_key <= aes_kin;
            aes_dvld <= 1'b0;
            if (aes_drdy) begin
                m_cnt <= 4'd11;
                m_din <= aes_din;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1'b1;
                if (m_cnt == 4'd1 && !hang) begin
                    aes_dvld <= 1'b1;
                    aes_dout <= core_f(m_key, m_din);
                end
            end
        end
    end
    assign aes_bsy = (m_cnt != 0);

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic [127:0] k);
        key_in = k; key_wr = 1'b1;
        tick();
        key_wr = 1'b0;
    endtask

    // Returns at the sample point just after the accepting edge.
    task automatic send_pt(input string tag, input logic [127:0] p);
        int waited = 0;
        pt_in = p; pt_valid = 1'b1; saw_krdy = 1'b0;
        while (!pt_ready && waited < 200) begin
            if (aes_krdy) begin saw_krdy = 1'b1; kin_seen = aes_kin; end
            tick();
            waited++;
        end
        chk1({tag, "_accept"}, pt_ready, 1'b1);
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic wait_ct(output int n);
        n = 0;
        trig_mid = 1'b0;
        do begin
            tick();
            n++;
            if (n == 5) trig_mid = trig;
        end while (!ct_valid && n < 60);
    endtask

    task automatic consume();
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic seen_a, seen_b;
        logic [127:0] p;

        // Reset state
        repeat (3) tick();
        chk1("rst_ct_valid", ct_valid, 1'b0);
        chkw("rst_ct_out", ct_out, '0);
        chkw("rst_op_cnt", 128'(op_cnt), '0);
        chk1("rst_pt_ready", pt_ready, 1'b0);
        chk1("rst_aes_en", aes_en, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_trig", trig, 1'b0);
        chk1("rst_krdy", aes_krdy, 1'b0);
        RSTn = 1'b1;
        tick();
        chk1("idle_aes_en", aes_en, 1'b1);

        // No key loaded: plaintext must never be accepted
        pt_valid = 1'b1; pt_in = P0; seen_a = 1'b0; seen_b = 1'b0;
        repeat (100) begin
            tick();
            seen_a |= pt_ready;
            seen_b |= aes_drdy;
        end
        pt_valid = 1'b0;
        chk1("nokey_pt_ready", seen_a, 1'b0);
        chk1("nokey_drdy", seen_b, 1'b0);

        // FIPS-197 vector, latency and op count
        write_key(K0);
        send_pt("t1", P0);
        wait_ct(n);
        chkw("t1_latency", 128'(n), 128'd14);
        chkw("t1_ct", ct_out, C0);
        chkw("t1_op_cnt", 128'(op_cnt), 128'd1);
`ifdef AES_SEQ_TRIG_EN
        chk1("t1_trig_mid", trig_mid, 1'b1);
`else
        chk1("t1_trig_mid", trig_mid, 1'b0);
`endif
        chk1("t1_trig_after", trig, 1'b0);
        consume();
        chk1("t1_ct_consumed", ct_valid, 1'b0);

        // Single result buffer: second pt waits for the first ct to be consumed
        p = 128'h00112233445566778899aabbccddeeff;
        send_pt("t3a", p);
        wait_ct(n);
        chkw("t3a_ct", ct_out, core_f(K0, p));
        chkw("t3a_op_cnt", 128'(op_cnt), 128'd2);
        pt_in = 128'h0123456789abcdef_fedcba9876543210; pt_valid = 1'b1; seen_a = 1'b0;
        repeat (20) begin
            tick();
            seen_a |= pt_ready;
        end
        chk1("t3_blocked", seen_a, 1'b0);
        chk1("t3_ct_held", ct_valid, 1'b1);
        chkw("t3_ct_kept", ct_out, core_f(K0, p));
        ct_ready = 1'b1;
        send_pt("t3b", 128'h0123456789abcdef_fedcba9876543210);
        ct_ready = 1'b0;
        wait_ct(n);
        chkw("t3b_latency", 128'(n), 128'd14);
        chkw("t3b_ct", ct_out, core_f(K0, 128'h0123456789abcdef_fedcba9876543210));
        chkw("t3b_op_cnt", 128'(op_cnt), 128'd3);
        consume();

        // Key writes during RUN: old key finishes, last write wins for the next pt
        p = 128'hcafebabe_01020304_05060708_090a0b0c;
        send_pt("t4a", p);
        repeat (5) tick();
        write_key(KX);
        write_key(K1);
        pt_in = 128'h55aa55aa_00ff00ff_12345678_9abcdef0; pt_valid = 1'b1;
        wait_ct(n);
        chkw("t4a_ct_oldkey", ct_out, core_f(K0, p));
        chk1("t4_pt_blocked", pt_ready, 1'b0);
        ct_ready = 1'b1;
        send_pt("t4b", 128'h55aa55aa_00ff00ff_12345678_9abcdef0);
        ct_ready = 1'b0;
        chk1("t4_key_reload", saw_krdy, 1'b1);
        chkw("t4_kin_last", kin_seen, K1);
        wait_ct(n);
        chkw("t4b_ct_newkey", ct_out, core_f(K1, 128'h55aa55aa_00ff00ff_12345678_9abcdef0));
        chkw("t4b_op_cnt", 128'(op_cnt), 128'd5);
        consume();

        // Watchdog timeout, then recovery through key_wr
        hang = 1'b1;
        send_pt("t5", 128'h1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!err && n < 60);
        chkw("t5_err_cycle", 128'(n), 128'd34);
        chk1("t5_err", err, 1'b1);
        pt_valid = 1'b1;
        tick();
        chk1("t5_aes_en", aes_en, 1'b0);
        chk1("t5_pt_ready", pt_ready, 1'b0);
        chk1("t5_no_ct", ct_valid, 1'b0);
        chkw("t5_op_cnt", 128'(op_cnt), 128'd5);
        pt_valid = 1'b0; hang = 1'b0;
        write_key(K1);
        chk1("t5_err_cleared", err, 1'b0);
        chk1("t5_aes_en_back", aes_en, 1'b1);
        send_pt("t5r", 128'h2);
        wait_ct(n);
        chkw("t5r_ct", ct_out, core_f(K1, 128'h2));
        chkw("t5r_op_cnt", 128'(op_cnt), 128'd6);
        consume();

        // Counter wrap at 2^CNT_W (CNT_W = 3)
        for (int i = 0; i < 3; i++) begin
            send_pt("wrap", 128'(i + 16));
            wait_ct(n);
            consume();
        end
        chkw("wrap_op_cnt", 128'(op_cnt), 128'd1);

        // Asynchronous reset in RUN
        send_pt("t6", 128'h77);
        repeat (5) tick();
        #2 RSTn = 1'b0;
        #1;
        chk1("t6_ct_valid", ct_valid, 1'b0);
        chkw("t6_ct_out", ct_out, '0);
        chkw("t6_op_cnt", 128'(op_cnt), '0);
        chk1("t6_aes_en", aes_en, 1'b0);
        chk1("t6_drdy", aes_drdy, 1'b0);
        chkw("t6_din", aes_din, '0);
        chkw("t6_kin", aes_kin, '0);
        tick();
        RSTn = 1'b1;
        seen_a = 1'b0; seen_b = 1'b0;
        repeat (30) begin
            tick();
            seen_a |= ct_valid;
            seen_b |= pt_ready;
        end
        chk1("t6_no_stale_ct", seen_a, 1'b0);
        chk1("t6_no_key", seen_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
